// File: rtl/div_defs.sv
// Shared definitions for the iterative 64-bit divider: FSM state encodings,
// the default operand width and the iteration-counter width helper.
package div_defs;

    localparam int DIV_BITS = 64;

    // Counter must hold the value BITS itself, hence BITS+1 codes.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divide_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// is non-negative and report the resulting quotient bit.
module divide_step #(
    parameter int BITS = 64
) (
    input  logic [BITS:0]   prem,
    input  logic            dvd_bit,
    input  logic [BITS-1:0] divisor,
    output logic [BITS:0]   prem_next,
    output logic            q_bit
);

    logic [BITS+1:0] shifted;
    logic [BITS+1:0] trial;

    // Shift-in and trial subtract; the top bit of the difference is its sign.
    always_comb begin
        shifted   = {prem, dvd_bit};
        trial     = shifted - {2'b00, divisor};
        q_bit     = ~trial[BITS+1];
        prem_next = q_bit ? trial[BITS:0] : shifted[BITS:0];
    end

endmodule

// File: rtl/divide_64x64.sv
// Iterative 64-bit integer divider (restoring, one quotient bit per cycle).
// Signed operands are reduced to magnitudes on acceptance and the signs are
// reapplied on the final iteration: quotient truncates toward zero, remainder
// follows the dividend sign. Divide-by-zero and MIN/-1 skip the iterations and
// report overflow with a zero quotient and remainder.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, and both are pure decodes of the
// state register so they follow reset immediately. The FSM state is visible on
// the internal signal "state" for checkers to bind to.
module divide_64x64
    import div_defs::*;
#(
    parameter int BITS = DIV_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            overflow
);

    localparam int CNT_W = cnt_width(BITS);

    state_t          state;
    state_t          state_next;
    logic [CNT_W-1:0] count;
    logic [BITS:0]   prem;
    logic [BITS-1:0] dvd_sr;     // dividend bits shift out the top, quotient bits fill the bottom
    logic [BITS-1:0] dvs;
    logic            qneg;
    logic            rneg;

    logic [BITS:0]   prem_next;
    logic            q_bit;
    logic [BITS-1:0] dividend_mag;
    logic [BITS-1:0] divisor_mag;
    logic [BITS-1:0] q_raw;
    logic [BITS-1:0] q_final;
    logic [BITS-1:0] r_final;
    logic            op_overflow;
    logic            accept;
    logic            last_step;

    divide_step #(.BITS(BITS)) u_step (
        .prem      (prem),
        .dvd_bit   (dvd_sr[BITS-1]),
        .divisor   (dvs),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // Operand conditioning, handshake decode and final sign fixup.
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        accept       = in_valid && in_ready;
        last_step    = (state == RUN) && (count == CNT_W'(1));
        dividend_mag = (is_signed && dividend[BITS-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed && divisor[BITS-1])  ? -divisor  : divisor;
        op_overflow  = (divisor == '0) ||
                       (is_signed && (dividend == {1'b1, {(BITS-1){1'b0}}}) && (divisor == '1));
        q_raw        = {dvd_sr[BITS-2:0], q_bit};
        q_final      = qneg ? -q_raw : q_raw;
        r_final      = rneg ? -prem_next[BITS-1:0] : prem_next[BITS-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: overflow cases bypass RUN entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)    state_next = op_overflow ? DONE : RUN;
            RUN:  if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            prem      <= '0;
            dvd_sr    <= '0;
            dvs       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                dvd_sr <= dividend_mag;
                dvs    <= divisor_mag;
                qneg   <= is_signed && (dividend[BITS-1] ^ divisor[BITS-1]);
                rneg   <= is_signed && dividend[BITS-1];
                prem   <= '0;
                if (op_overflow) begin
                    count     <= '0;
                    quotient  <= '0;
                    remainder <= '0;
                    overflow  <= 1'b1;
                end else begin
                    count <= CNT_W'(BITS);
                end
            end
            if (state == RUN) begin
                prem   <= prem_next;
                dvd_sr <= q_raw;
                count  <= count - CNT_W'(1);
                if (last_step) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                    overflow  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_divide_64x64.sv
// Directed bench for divide_64x64: a table of hand-computed divides plus
// sequences for result hold, reset mid-operation and back-to-back issue.
module tb_divide_64x64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        overflow;

    int n_checks = 0;
    int n_fail = 0;

    divide_64x64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
        logic [63:0] q;
        logic [63:0] r;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request and wait (bounded) for it to be accepted; returns at
    // the falling edge after the acceptance edge with in_valid dropped.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sgn);
        int waited;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        in_valid  = 1'b1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance (inclusive) until out_valid is seen.
    task automatic wait_result(output int lat, output bit ir_low);
        lat = 1;
        ir_low = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_low = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready) ir_low = 1'b0;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        check({name, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int          lat;
        bit          ir_low;
        logic [63:0] hq;
        logic [63:0] hr;

        vecs[0]  = '{"u_100_7",     64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 65};
        vecs[1]  = '{"s_m7_2",      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65};
        vecs[2]  = '{"s_7_m2",      64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65};
        vecs[3]  = '{"u_div0",      64'd5, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1};
        vecs[4]  = '{"s_div0",      64'd5, 64'd0, 1'b1, 64'd0, 64'd0, 1'b1, 1};
        vecs[5]  = '{"s_min_m1",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                     64'd0, 64'd0, 1'b1, 1};
        vecs[6]  = '{"u_max_1",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65};
        vecs[7]  = '{"u_1000_10",   64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 1'b0, 65};
        vecs[8]  = '{"u_min_max",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'd0, 64'h8000_0000_0000_0000, 1'b0, 65};
        vecs[9]  = '{"s_m100_7",    64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
        vecs[10] = '{"s_m100_m7",   64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
                     64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
        vecs[11] = '{"u_3_5",       64'd3, 64'd5, 1'b0, 64'd0, 64'd3, 1'b0, 65};
        vecs[12] = '{"s_min_1",     64'h8000_0000_0000_0000, 64'd1, 1'b1,
                     64'h8000_0000_0000_0000, 64'd0, 1'b0, 65};
        vecs[13] = '{"s_min_2",     64'h8000_0000_0000_0000, 64'd2, 1'b1,
                     64'hC000_0000_0000_0000, 64'd0, 1'b0, 65};

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sgn);
            wait_result(lat, ir_low);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_in_ready_low"}, 64'(ir_low), 64'd1);
            check({vecs[i].name, "_quotient"}, quotient, vecs[i].q);
            check({vecs[i].name, "_remainder"}, remainder, vecs[i].r);
            check({vecs[i].name, "_overflow"}, 64'(overflow), 64'(vecs[i].ov));
            consume(vecs[i].name);
        end

        // Result held while out_ready is low; in_valid ignored in DONE
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_result(lat, ir_low);
        hq = quotient;
        hr = remainder;
        check("hold_quotient", hq, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hold_remainder", hr, 64'd0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dividend = 64'(c + 20);
            divisor  = 64'd3;
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_q_stable", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
            check("hold_r_stable", remainder, 64'd0);
            check("hold_ov_stable", 64'(overflow), 64'd0);
        end
        in_valid = 1'b0;
        consume("hold");

        // Reset during RUN, at iteration 30
        issue(64'd100, 64'd7, 1'b0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_quotient", quotient, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(64'd1000, 64'd10, 1'b0);
        wait_result(lat, ir_low);
        check("postrst_latency", 64'(lat), 64'd65);
        check("postrst_quotient", quotient, 64'd100);
        check("postrst_remainder", remainder, 64'd0);
        consume("postrst");

        // Back-to-back: second request waits on in_valid through the first op
        issue(64'd100, 64'd7, 1'b0);
        dividend  = 64'd1000;
        divisor   = 64'd10;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        wait_result(lat, ir_low);
        check("b2b_first_latency", 64'(lat), 64'd65);
        check("b2b_first_quotient", quotient, 64'd14);
        check("b2b_first_remainder", remainder, 64'd2);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_gap_in_ready", 64'(in_ready), 64'd1);
        check("b2b_gap_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accepted", 64'(in_ready), 64'd0);
        wait_result(lat, ir_low);
        check("b2b_second_latency", 64'(lat), 64'd65);
        check("b2b_second_quotient", quotient, 64'd100);
        check("b2b_second_remainder", remainder, 64'd0);
        consume("b2b_second");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divide_64x64.md
Name: divide_64x64

Overview:
Iterative, multi-cycle 64-bit integer divider: the inverse of multiply_add_64x64 in the ASIC behavioural arithmetic set. It accepts one divide per handshake and produces quotient and remainder by restoring division, one quotient bit per cycle. Divide-by-zero and signed overflow are flagged. It sits beside the multiplier in the execution unit and is driven by the same issue logic, but uses a valid/ready handshake because its latency is long.

Parameters:
BITS, 64, operand width; quotient and remainder are BITS wide; iteration count equals BITS.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE; the operation is accepted on a clk edge where in_valid and in_ready are both high.
dividend  input  BITS  numerator; sampled at acceptance.
divisor  input  BITS  denominator; sampled at acceptance.
is_signed  input  1  1 = two's-complement operands; 0 = unsigned; sampled at acceptance.
out_valid  output  1  result available; held until consumed.
out_ready  input  1  consumer accepts the result on an edge where out_valid and out_ready are both high.
quotient  output  BITS  quotient result.
remainder  output  BITS  remainder result.
overflow  output  1  1 = divide-by-zero or signed overflow.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (immediate on rst): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0, iteration counter=0.
- State IDLE:
  - in_ready=1.
  - On acceptance, latch |dividend| and |divisor| (magnitudes only when is_signed=1), plus the result signs: qneg = sign(dividend) XOR sign(divisor), rneg = sign(dividend).
  - If divisor==0, or is_signed and dividend==2^(BITS-1) and divisor==all-ones: go to DONE next edge with quotient=0, remainder=0, overflow=1. Latency is 1 edge.
  - Otherwise go to RUN with counter=BITS and partial remainder=0.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each edge: shift the partial remainder left one bit, bringing in the next dividend MSB. Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0. Decrement the counter.
  - On the edge where the counter goes 1→0: apply sign fixup (negate quotient if qneg; negate remainder if rneg), set overflow=0, and enter DONE.
  - out_valid rises exactly BITS+1 edges after the acceptance edge (65 for BITS=64).
- State DONE:
  - out_valid=1, in_ready=0. quotient, remainder and overflow are stable while out_valid=1 and out_ready=0.
  - On the edge with out_ready=1: go to IDLE and clear out_valid. Result registers keep their values, so they are don't-care when out_valid=0.
  - in_valid in the same cycle is ignored (in_ready=0). Minimum issue interval is BITS+2 cycles for a normal divide, 2 cycles for an overflow case.
- Inputs are ignored outside the acceptance edge; changing them during RUN has no effect.
- Reset mid-operation: the RUN or DONE operation is discarded, no result is produced, and the block returns to reset values. The first accept after reset deasserts behaves normally.
- Widths: the partial remainder is BITS+1 bits so the trial subtract carries no extra sign logic. Negation is two's complement mod 2^BITS.
- Signed result convention: quotient truncates toward zero; remainder takes the sign of the dividend.

Decomposition:
- Shared package (div_defs): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2, and the counter width localparam $clog2(BITS+1).
- One combinational sub-module, divide_step: inputs are partial remainder, next dividend bit and divisor; outputs are the new partial remainder and the quotient bit. It is instantiated once in RUN.

Test Plan:
- Unsigned 100 / 7 → quotient=14, remainder=2, overflow=0; out_valid exactly 65 edges after acceptance; in_ready=0 throughout.
- Signed -7 / 2 → quotient=-3 (0xFFFF_FFFF_FFFF_FFFD), remainder=-1; signed 7 / -2 → quotient=-3, remainder=1.
- Divide by zero (dividend=5, divisor=0, either sign mode) → overflow=1, quotient=0, remainder=0, out_valid 1 edge after acceptance; signed 0x8000_0000_0000_0000 / -1 → same flags.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF / 1 → quotient=all-ones, remainder=0; hold out_ready=0 for 5 cycles → outputs stable, in_valid ignored; out_ready=1 → IDLE next edge, in_ready=1.
- Assert rst at RUN iteration 30 → out_valid=0 and in_ready=1 immediately; next op 1000 / 10 → quotient=100, remainder=0 with full 65-edge latency.
- Back-to-back: the second request is held on in_valid during the first op → accepted only in the IDLE cycle after the first result is consumed; both results correct.
